axi_stream_strip_header: RTL and testbench



---
 rtl/axis_hdr_pkg.sv | 47 ++++
 rtl/axis_out_reg.sv | 34 +++
 rtl/axi_stream_strip_header.sv | 222 ++++++++++++++++++++++
 tb/tb_axi_stream_strip_header.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_hdr_pkg.sv
// Shared definitions for the AXI-Stream header insert/strip blocks:
// strip FSM state encoding, default widths and byte-lane helpers.
package axis_hdr_pkg;

    localparam int DEFAULT_DATA_WD      = 32;
    localparam int DEFAULT_DATA_BYTE_WD = DEFAULT_DATA_WD / 8;
    // Widest beat the helpers below can describe (512-bit data).
    localparam int MAX_BYTE_WD          = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        BODY  = 2'd2,
        FLUSH = 2'd3
    } strip_state_t;

    // Number of set byte enables.
    function automatic int popcount(input logic [MAX_BYTE_WD-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < MAX_BYTE_WD; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

    // A w-bit all-ones mask shifted right by n: the low (w-n) bits set.
    function automatic logic [MAX_BYTE_WD-1:0] ones_shr(input int w, input int n);
        logic [MAX_BYTE_WD-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_BYTE_WD; i++) begin
            if (i < w - n) r[i] = 1'b1;
        end
        return r;
    endfunction

    // A w-bit all-ones mask shifted left by n: bits [w-1:n] set.
    function automatic logic [MAX_BYTE_WD-1:0] ones_shl(input int w, input int n);
        logic [MAX_BYTE_WD-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_BYTE_WD; i++) begin
            if (i >= n && i < w) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// One-deep registered valid/ready stage. Accepts a new word whenever the
// output is empty or being consumed, so it sustains one word per cycle,
// and holds its word stable while out_valid is high and out_ready is low.
module axis_out_reg
    import axis_hdr_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    // Load on input handshake, otherwise empty once the word is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_stream_strip_header.sv
// Strips byte_strip_cnt leading bytes from each AXI-Stream packet, sends
// them right-aligned on the header channel and re-packs the remaining
// payload so every beat is full except the last.
// Handshake rule on every channel: a transfer happens on a rising clk edge
// where valid and ready are both high; a source keeps valid and its payload
// stable until that edge, and ready may depend combinationally on state.
// Optional macro AXIS_STRIP_SHORT_ERR_EN adds err_short, a one-cycle pulse
// when a packet ends on its first beat before the header is complete.
module axi_stream_strip_header
    import axis_hdr_pkg::*;
#(
    parameter int DATA_WD      = DEFAULT_DATA_WD,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    input  logic                    valid_strip,
    output logic                    ready_strip,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    output logic                    valid_hdr,
    input  logic                    ready_hdr,
    output logic [DATA_WD-1:0]      data_hdr,
    output logic [DATA_BYTE_WD-1:0] keep_hdr,
`ifdef AXIS_STRIP_SHORT_ERR_EN
    output logic                    err_short,
`endif
    output strip_state_t            state_dbg
);

    localparam int PAY_W = DATA_WD + DATA_BYTE_WD + 1;
    localparam int HW    = DATA_WD + DATA_BYTE_WD;

    strip_state_t             state_q;
    logic [BYTE_CNT_WD-1:0]   cnt_q;
    logic                     bypass_q;
    logic [DATA_WD-1:0]       residue_q;   // previous beat; only its low bytes survive the merge shift
    logic [BYTE_CNT_WD:0]     tail_q;      // payload bytes left for the flush beat

    logic                     pay_push_valid;
    logic                     pay_push_ready;
    logic [DATA_WD-1:0]       pay_data;
    logic [DATA_BYTE_WD-1:0]  pay_keep;
    logic                     pay_last;
    logic [PAY_W-1:0]         pay_q;

    logic                     hdr_push_valid;
    logic                     hdr_push_ready;
    logic [DATA_WD-1:0]       hdr_data;
    logic [DATA_BYTE_WD-1:0]  hdr_keep;
    logic [HW-1:0]            hdr_q;

    int                       c;
    int                       k_in;
    int                       hdr_n;
    logic                     accept;

    // Expand per-byte enables into a bit mask so invalid lanes read as zero.
    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            m[8*i +: 8] = {8{k[i]}};
        end
        return m;
    endfunction

    assign ready_strip = (state_q == IDLE) && !rst;
    assign state_dbg   = state_q;

    // Datapath: header extraction, payload merge/flush and input ready.
    always_comb begin
        c     = int'(cnt_q);
        k_in  = popcount(MAX_BYTE_WD'(keep_in));
        // A packet that ends inside the header only yields the bytes it has.
        hdr_n = (last_in && k_in < c) ? k_in : c;

        hdr_push_valid = (state_q == HDR) && valid_in;
        hdr_data       = data_in >> (8 * (DATA_BYTE_WD - hdr_n));
        hdr_keep       = DATA_BYTE_WD'(ones_shr(DATA_BYTE_WD, DATA_BYTE_WD - hdr_n));

        ready_in       = 1'b0;
        pay_push_valid = 1'b0;
        pay_data       = '0;
        pay_keep       = '0;
        pay_last       = 1'b0;

        case (state_q)
            HDR: begin
                ready_in = hdr_push_ready;
            end
            BODY: begin
                ready_in       = pay_push_ready;
                pay_push_valid = valid_in;
                if (bypass_q) begin
                    pay_data = data_in;
                    pay_keep = keep_in;
                    pay_last = last_in;
                end else begin
                    if (last_in && k_in <= c) begin
                        pay_keep = DATA_BYTE_WD'(ones_shl(DATA_BYTE_WD, c - k_in));
                        pay_last = 1'b1;
                    end else begin
                        pay_keep = '1;
                        pay_last = 1'b0;
                    end
                    pay_data = ((residue_q << (8 * c)) |
                                (data_in >> (8 * (DATA_BYTE_WD - c)))) & byte_mask(pay_keep);
                end
            end
            FLUSH: begin
                pay_push_valid = 1'b1;
                pay_keep       = DATA_BYTE_WD'(ones_shl(DATA_BYTE_WD, DATA_BYTE_WD - int'(tail_q)));
                pay_last       = 1'b1;
                pay_data       = (residue_q << (8 * c)) & byte_mask(pay_keep);
            end
            default: begin
            end
        endcase

        accept = valid_in && ready_in;
    end

    // Control FSM: config latch, header beat, merged body, trailing flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bypass_q  <= 1'b0;
            residue_q <= '0;
            tail_q    <= '0;
`ifdef AXIS_STRIP_SHORT_ERR_EN
            err_short <= 1'b0;
`endif
        end else begin
`ifdef AXIS_STRIP_SHORT_ERR_EN
            err_short <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (valid_strip) begin
                        cnt_q    <= byte_strip_cnt;
                        bypass_q <= (byte_strip_cnt == '0);
                        state_q  <= (byte_strip_cnt == '0) ? BODY : HDR;
                    end
                end
                HDR: begin
                    if (accept) begin
                        residue_q <= data_in;
                        if (last_in) begin
                            if (k_in > c) begin
                                tail_q  <= (BYTE_CNT_WD+1)'(k_in - c);
                                state_q <= FLUSH;
                            end else begin
                                state_q <= IDLE;
                            end
`ifdef AXIS_STRIP_SHORT_ERR_EN
                            err_short <= (k_in < c);
`endif
                        end else begin
                            state_q <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (accept) begin
                        residue_q <= data_in;
                        if (last_in) begin
                            if (bypass_q || k_in <= c) begin
                                state_q <= IDLE;
                            end else begin
                                tail_q  <= (BYTE_CNT_WD+1)'(k_in - c);
                                state_q <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (pay_push_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    axis_out_reg #(.W(PAY_W)) u_pay_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (pay_push_valid),
        .in_ready  (pay_push_ready),
        .in_data   ({pay_data, pay_keep, pay_last}),
        .out_valid (valid_out),
        .out_ready (ready_out),
        .out_data  (pay_q)
    );

    assign {data_out, keep_out, last_out} = pay_q;

    axis_out_reg #(.W(HW)) u_hdr_reg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (hdr_push_valid),
        .in_ready  (hdr_push_ready),
        .in_data   ({hdr_data, hdr_keep}),
        .out_valid (valid_hdr),
        .out_ready (ready_hdr),
        .out_data  (hdr_q)
    );

    assign {data_hdr, keep_hdr} = hdr_q;

endmodule

// File: tb/tb_axi_stream_strip_header.sv
// Directed bench for axi_stream_strip_header (DATA_WD=32). Expected beats
// are hand-computed and queued before each packet; monitors pop and compare.
module tb_axi_stream_strip_header;
    import axis_hdr_pkg::*;

    localparam int DATA_WD = 32;
    localparam int NB      = 4;
    localparam int CW      = 2;

    logic               clk;
    logic               rst;
    logic               valid_in;
    logic               ready_in;
    logic [DATA_WD-1:0] data_in;
    logic [NB-1:0]      keep_in;
    logic               last_in;
    logic               valid_strip;
    logic               ready_strip;
    logic [CW-1:0]      byte_strip_cnt;
    logic               valid_out;
    logic               ready_out;
    logic [DATA_WD-1:0] data_out;
    logic [NB-1:0]      keep_out;
    logic               last_out;
    logic               valid_hdr;
    logic               ready_hdr;
    logic [DATA_WD-1:0] data_hdr;
    logic [NB-1:0]      keep_hdr;
    strip_state_t       state_dbg;
`ifdef AXIS_STRIP_SHORT_ERR_EN
    logic               err_short;
    int                 err_pulses = 0;
`endif

    int checks = 0;
    int errors = 0;
    int pay_seen = 0;
    int hdr_seen = 0;

    logic [DATA_WD+NB:0]   exp_pay_q[$];
    logic [DATA_WD+NB-1:0] exp_hdr_q[$];

    axi_stream_strip_header dut (
        .clk            (clk),
        .rst            (rst),
        .valid_in       (valid_in),
        .ready_in       (ready_in),
        .data_in        (data_in),
        .keep_in        (keep_in),
        .last_in        (last_in),
        .valid_strip    (valid_strip),
        .ready_strip    (ready_strip),
        .byte_strip_cnt (byte_strip_cnt),
        .valid_out      (valid_out),
        .ready_out      (ready_out),
        .data_out       (data_out),
        .keep_out       (keep_out),
        .last_out       (last_out),
        .valid_hdr      (valid_hdr),
        .ready_hdr      (ready_hdr),
        .data_hdr       (data_hdr),
        .keep_hdr       (keep_hdr),
`ifdef AXIS_STRIP_SHORT_ERR_EN
        .err_short      (err_short),
`endif
        .state_dbg      (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: payload beats
    always @(negedge clk) begin
        if (!rst && valid_out && ready_out) begin
            pay_seen++;
            if (exp_pay_q.size() == 0) begin
                check("pay_unexpected", 64'(exp_pay_q.size()), 64'd1);
            end else begin
                check("pay_beat", 64'({data_out, keep_out, last_out}), 64'(exp_pay_q.pop_front()));
            end
        end
    end

    // Scoreboard: header beats
    always @(negedge clk) begin
        if (!rst && valid_hdr && ready_hdr) begin
            hdr_seen++;
            if (exp_hdr_q.size() == 0) begin
                check("hdr_unexpected", 64'(exp_hdr_q.size()), 64'd1);
            end else begin
                check("hdr_beat", 64'({data_hdr, keep_hdr}), 64'(exp_hdr_q.pop_front()));
            end
        end
    end

`ifdef AXIS_STRIP_SHORT_ERR_EN
    always @(negedge clk) begin
        if (!rst && err_short) err_pulses++;
    end
`endif

    // Driver tasks
    task automatic send_cfg(input logic [CW-1:0] cnt);
        logic ok;
        ok = 1'b0;
        valid_strip    = 1'b1;
        byte_strip_cnt = cnt;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready_strip) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        valid_strip = 1'b0;
        check("cfg_accept", 64'(ok), 64'd1);
    endtask

    task automatic send_beat(input logic [DATA_WD-1:0] d, input logic [NB-1:0] k, input logic l);
        logic ok;
        ok = 1'b0;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready_in) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        check("in_accept", 64'(ok), 64'd1);
    endtask

    task automatic end_pkt();
        valid_in = 1'b0;
        data_in  = '0;
        keep_in  = '0;
        last_in  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_pay_q.size() == 0 && exp_hdr_q.size() == 0) break;
        end
        check("drain", 64'(exp_pay_q.size() + exp_hdr_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic pkt_scenario1();
        exp_hdr_q.push_back({32'h00AABBCC, 4'b0111});
        exp_pay_q.push_back({32'hDD112233, 4'b1111, 1'b0});
        exp_pay_q.push_back({32'h44556600, 4'b1110, 1'b1});
        send_cfg(2'd3);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        check("s1_hdr_latency", 64'(valid_hdr), 64'd1);
        check("s1_no_early_pay", 64'(valid_out), 64'd0);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        check("s1_pay_latency", 64'(valid_out), 64'd1);
        send_beat(32'h55667788, 4'b1100, 1'b1);
        end_pkt();
        drain();
    endtask

    // Stimulus
    initial begin
        int p0;
        int h0;
        rst            = 1'b1;
        valid_in       = 1'b0;
        data_in        = '0;
        keep_in        = '0;
        last_in        = 1'b0;
        valid_strip    = 1'b0;
        byte_strip_cnt = '0;
        ready_out      = 1'b1;
        ready_hdr      = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_valid_hdr", 64'(valid_hdr), 64'd0);
        check("rst_last_out", 64'(last_out), 64'd0);
        check("rst_ready_in", 64'(ready_in), 64'd0);
        check("rst_ready_strip", 64'(ready_strip), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_keep_out", 64'(keep_out), 64'd0);
        check("rst_data_hdr", 64'(data_hdr), 64'd0);
        check("rst_keep_hdr", 64'(keep_hdr), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_state", 64'(state_dbg), 64'(IDLE));
        check("idle_ready_strip", 64'(ready_strip), 64'd1);
        check("idle_ready_in", 64'(ready_in), 64'd0);
        @(posedge clk);
        #1;

        // 1: merged last beat
        pkt_scenario1();

        // 2: flush beat
        exp_hdr_q.push_back({32'h0000AABB, 4'b0011});
        exp_pay_q.push_back({32'hCCDD1122, 4'b1111, 1'b0});
        exp_pay_q.push_back({32'h33000000, 4'b1000, 1'b1});
        send_cfg(2'd2);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1110, 1'b1);
        end_pkt();
        drain();

        // 3: payload backpressure on scenario 1
        exp_hdr_q.push_back({32'h00AABBCC, 4'b0111});
        exp_pay_q.push_back({32'hDD112233, 4'b1111, 1'b0});
        exp_pay_q.push_back({32'h44556600, 4'b1110, 1'b1});
        fork
            begin
                send_cfg(2'd3);
                send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
                send_beat(32'h11223344, 4'b1111, 1'b0);
                send_beat(32'h55667788, 4'b1100, 1'b1);
                end_pkt();
            end
            begin
                logic seen;
                seen = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(posedge clk);
                    #1;
                    if (valid_out) begin
                        seen = 1'b1;
                        break;
                    end
                end
                ready_out = 1'b0;
                check("bp_first_pay_seen", 64'(seen), 64'd1);
                repeat (5) begin
                    @(negedge clk);
                    check("bp_valid_held", 64'(valid_out), 64'd1);
                    check("bp_beat_held", 64'({data_out, keep_out, last_out}),
                          64'({32'hDD112233, 4'b1111, 1'b0}));
                    check("bp_ready_in_low", 64'(ready_in), 64'd0);
                end
                @(posedge clk);
                #1;
                ready_out = 1'b1;
            end
        join
        drain();

        // 4: header backpressure across two packets
        ready_hdr = 1'b0;
        exp_hdr_q.push_back({32'h0000AABB, 4'b0011});
        exp_hdr_q.push_back({32'h00000001, 4'b0001});
        exp_pay_q.push_back({32'hCCDD1122, 4'b1111, 1'b0});
        exp_pay_q.push_back({32'h33000000, 4'b1000, 1'b1});
        exp_pay_q.push_back({32'h02030405, 4'b1111, 1'b0});
        exp_pay_q.push_back({32'h06070800, 4'b1110, 1'b1});
        p0 = pay_seen;
        send_cfg(2'd2);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'h11223344, 4'b1110, 1'b1);
        end_pkt();
        repeat (4) @(posedge clk);
        #1;
        check("hb_payload_not_blocked", 64'(pay_seen - p0), 64'd2);
        fork
            begin
                send_cfg(2'd1);
                send_beat(32'h01020304, 4'b1111, 1'b0);
                send_beat(32'h05060708, 4'b1111, 1'b1);
                end_pkt();
            end
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("hb_ready_in_blocked", 64'(ready_in), 64'd0);
                    check("hb_hdr_pending", 64'(valid_hdr), 64'd1);
                end
                check("hb_state_hdr", 64'(state_dbg), 64'(HDR));
                @(posedge clk);
                #1;
                ready_hdr = 1'b1;
            end
        join
        drain();

        // 5: bypass
        h0 = hdr_seen;
        exp_pay_q.push_back({32'h01020304, 4'b1111, 1'b0});
        exp_pay_q.push_back({32'h05060708, 4'b1100, 1'b1});
        send_cfg(2'd0);
        send_beat(32'h01020304, 4'b1111, 1'b0);
        valid_in = 1'b0;
        check("byp_latency", 64'(valid_out), 64'd1);
        send_beat(32'h05060708, 4'b1100, 1'b1);
        end_pkt();
        drain();
        check("byp_no_hdr", 64'(hdr_seen - h0), 64'd0);

        // 6: short packet
        p0 = pay_seen;
        exp_hdr_q.push_back({32'h0000AABB, 4'b0011});
        send_cfg(2'd3);
        send_beat(32'hAABB0000, 4'b1100, 1'b1);
        end_pkt();
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("short_no_pay", 64'(pay_seen - p0), 64'd0);
        check("short_back_idle", 64'(state_dbg), 64'(IDLE));
`ifdef AXIS_STRIP_SHORT_ERR_EN
        check("short_err_pulse", 64'(err_pulses), 64'd1);
`endif

        // 7: data presented before config, last beat with k == cnt
        exp_hdr_q.push_back({32'h000000CA, 4'b0001});
        exp_pay_q.push_back({32'hFEBABE12, 4'b1111, 1'b1});
        valid_in = 1'b1;
        data_in  = 32'hCAFEBABE;
        keep_in  = 4'b1111;
        last_in  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("precfg_ready_in", 64'(ready_in), 64'd0);
        end
        @(posedge clk);
        #1;
        send_cfg(2'd1);
        send_beat(32'hCAFEBABE, 4'b1111, 1'b0);
        send_beat(32'h12345678, 4'b1000, 1'b1);
        end_pkt();
        drain();

        // 8: reset mid-packet, then a clean packet
        exp_hdr_q.push_back({32'h0000AABB, 4'b0011});
        send_cfg(2'd2);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        end_pkt();
        repeat (3) @(posedge clk);
        #1;
        check("mid_state_body", 64'(state_dbg), 64'(BODY));
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_state", 64'(state_dbg), 64'(IDLE));
        check("mid_rst_valid_out", 64'(valid_out), 64'd0);
        check("mid_rst_ready_strip", 64'(ready_strip), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pkt_scenario1();

        check("final_pay_q_empty", 64'(exp_pay_q.size()), 64'd0);
        check("final_hdr_q_empty", 64'(exp_hdr_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
